accumulate: RTL and testbench

ACCUMULATE -- requirements
Module: accumulate

---
 rtl/fp_pkg.sv | 34 +++
 rtl/fp_add.sv | 126 ++++++++++++
 rtl/accumulate.sv | 75 +++++++
 tb/tb_accumulate.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - FP32 field widths, special constants, accumulator state enum
// Shared by fp_add and accumulate; no ports.
package fp_pkg;

   localparam int FP_SIGN_W = 1;
   localparam int FP_EXP_W  = 8;
   localparam int FP_MAN_W  = 23;
   localparam int FP_BIAS   = 127;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FP_INF  = 32'h7F80_0000;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // Leading-zero count of the 27-bit working significand (27 when all zero).
   function automatic logic [4:0] clz27(input logic [26:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd27;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found && v[i]) begin
            n     = 5'(26 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/fp_add.sv
// rtl/fp_add.sv - combinational FP32 adder, round-to-nearest-even, subnormals flushed
// Ports:
//   a, b : FP32 operands
//   sum  : FP32 a+b (NaN/inf-inf -> FP_QNAN, overflow -> signed inf,
//          exact cancellation -> +0, subnormal in/out -> signed zero)
module fp_add
   import fp_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);

   logic                sa, sb;
   logic [FP_EXP_W-1:0] ea, eb;
   logic [FP_MAN_W-1:0] ma, mb;
   logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign sa = a[31];
   assign sb = b[31];
   assign ea = a[30 -: FP_EXP_W];
   assign eb = b[30 -: FP_EXP_W];
   assign ma = a[FP_MAN_W-1:0];
   assign mb = b[FP_MAN_W-1:0];

   // Exponent field 0 covers both true zero and subnormals: both read as zero.
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == '1) && (ma == '0);
   assign b_inf  = (eb == '1) && (mb == '0);
   assign a_nan  = (ea == '1) && (ma != '0);
   assign b_nan  = (eb == '1) && (mb != '0);

   logic                swap;
   logic                s_big, s_small;
   logic [FP_EXP_W-1:0] e_big, e_small;
   logic [26:0]         m_big, m_small, m_shift, mask;
   logic [7:0]          diff;
   logic [27:0]         raw;
   logic [26:0]         norm;
   logic [4:0]          lz;
   logic signed [9:0]   e_norm, e_fin;
   logic                rnd_up;
   logic [24:0]         rnd;
   logic [FP_MAN_W-1:0] m_fin;

   always_comb begin
      mask    = '0;
      m_shift = '0;
      raw     = '0;
      norm    = '0;
      lz      = '0;
      e_norm  = '0;
      e_fin   = '0;
      rnd_up  = 1'b0;
      rnd     = '0;
      m_fin   = '0;
      sum     = FP_ZERO;

      // Order operands by magnitude so the subtraction below never goes negative.
      swap    = {eb, mb} > {ea, ma};
      s_big   = swap ? sb : sa;
      s_small = swap ? sa : sb;
      e_big   = swap ? eb : ea;
      e_small = swap ? ea : eb;
      // Hidden one, 23 fraction bits, then guard/round/sticky.
      m_big   = {1'b1, (swap ? mb : ma), 3'b000};
      m_small = {1'b1, (swap ? ma : mb), 3'b000};
      diff    = e_big - e_small;

      if (diff > 8'd26) begin
         m_shift = 27'd1;
      end else begin
         mask    = (27'd1 << diff) - 27'd1;
         m_shift = (m_small >> diff) | {26'd0, |(m_small & mask)};
      end

      if (s_big == s_small)
         raw = {1'b0, m_big} + {1'b0, m_shift};
      else
         raw = {1'b0, m_big} - {1'b0, m_shift};

      if (raw[27]) begin
         norm   = raw[27:1] | {26'd0, raw[0]};
         e_norm = $signed({2'b00, e_big}) + 10'sd1;
      end else begin
         lz     = clz27(raw[26:0]);
         norm   = raw[26:0] << lz;
         e_norm = $signed({2'b00, e_big}) - $signed({5'd0, lz});
      end

      rnd_up = norm[2] & (norm[3] | norm[1] | norm[0]);
      rnd    = {1'b0, norm[26:3]} + {24'd0, rnd_up};
      if (rnd[24]) begin
         m_fin = rnd[23:1];
         e_fin = e_norm + 10'sd1;
      end else begin
         m_fin = rnd[22:0];
         e_fin = e_norm;
      end

      if (a_nan || b_nan)
         sum = FP_QNAN;
      else if (a_inf && b_inf)
         sum = (sa != sb) ? FP_QNAN : a;
      else if (a_inf)
         sum = a;
      else if (b_inf)
         sum = b;
      else if (a_zero && b_zero)
         sum = {sa & sb, 31'd0};
      else if (a_zero)
         sum = b;
      else if (b_zero)
         sum = a;
      else if (raw == '0)
         sum = FP_ZERO;
      else if (e_fin >= 10'sd255)
         sum = {s_big, FP_INF[30:0]};
      else if (e_fin <= 10'sd0)
         sum = {s_big, 31'd0};
      else
         sum = {s_big, e_fin[7:0], m_fin};
   end

endmodule

// File: rtl/accumulate.sv
// rtl/accumulate.sv - FP32 running-sum accumulator with start/finished framing
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : clear sum and enter ACCUM (also restarts from ACCUM)
//   valid,data : add data to the sum this cycle (ACCUM only)
//   finished   : close accumulation; done pulses the following cycle
//   result     : sum register
//   done       : one-cycle pulse, result holds the final sum
module accumulate
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        valid,
   input  logic [31:0] data,
   input  logic        finished,
   output logic [31:0] result,
   output logic        done
);

   state_t      state, state_next;
   logic [31:0] sum_q, sum_next, add_out;
   logic        done_q, done_next;

   fp_add u_fp_add (
      .a   (sum_q),
      .b   (data),
      .sum (add_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sum_q  <= FP_ZERO;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         sum_q  <= sum_next;
         done_q <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      sum_next   = sum_q;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = ACCUM;
               sum_next   = FP_ZERO;
            end
         end
         ACCUM: begin
            // start wins over valid/finished: the frame simply reopens.
            if (start) begin
               sum_next = FP_ZERO;
            end else begin
               if (valid)
                  sum_next = add_out;
               if (finished) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign result = sum_q;
   assign done   = done_q;

endmodule

// File: tb/tb_accumulate.sv
// tb/tb_accumulate.sv - scoreboard testbench for accumulate
module tb_accumulate;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        valid;
   logic [31:0] data;
   logic        finished;
   logic [31:0] result;
   logic        done;

   accumulate dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .valid    (valid),
      .data     (data),
      .finished (finished),
      .result   (result),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] r;
      logic        d;
      int          tag;
   } exp_t;

   exp_t q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   n_tag      = 0;
   event sample_ev;

   // Outputs are sampled 2 time units after each rising edge.
   always @(posedge clk) begin
      #2;
      -> sample_ev;
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(sample_ev);
         if (q.size() > 0) begin
            e = q.pop_front();
            compared++;
            if (result !== e.r || done !== e.d) begin
               mismatched++;
               $display("FAIL check_%0d: result=%h done=%b, expected result=%h done=%b",
                        e.tag, result, done, e.r, e.d);
            end
         end
      end
   end

   task automatic push_exp(input logic [31:0] er, input logic ed);
      exp_t e;
      e.r   = er;
      e.d   = ed;
      e.tag = n_tag;
      n_tag++;
      q.push_back(e);
   endtask

   // Drive one cycle of inputs at the falling edge; expectation is the
   // state visible after the following rising edge.
   task automatic step(input logic st, input logic v, input logic [31:0] dt,
                       input logic f, input logic [31:0] er, input logic ed);
      @(negedge clk);
      start    = st;
      valid    = v;
      data     = dt;
      finished = f;
      push_exp(er, ed);
   endtask

   // Assert reset between edges and check outputs without waiting for a clock.
   task automatic async_reset_check();
      @(negedge clk);
      start    = 1'b0;
      valid    = 1'b0;
      finished = 1'b0;
      #2;
      rst_n = 1'b0;
      push_exp(32'h0000_0000, 1'b0);
      #1;
      -> sample_ev;
   endtask

   localparam logic [31:0] ONE = 32'h3F80_0000;

   initial begin : stimulus
      rst_n    = 1'b0;
      start    = 1'b0;
      valid    = 1'b0;
      data     = '0;
      finished = 1'b0;
      #3;
      push_exp(32'h0000_0000, 1'b0);
      -> sample_ev;
      @(negedge clk);
      rst_n = 1'b1;

      // Four back-to-back 1.0 samples
      step(1, 0, 0,   0, 32'h0000_0000, 0);
      step(0, 1, ONE, 0, 32'h3F80_0000, 0);
      step(0, 1, ONE, 0, 32'h4000_0000, 0);
      step(0, 1, ONE, 0, 32'h4040_0000, 0);
      step(0, 1, ONE, 0, 32'h4080_0000, 0);
      // Hold, then sparse pulses, then finished
      for (int i = 0; i < 3; i++) step(0, 0, ONE, 0, 32'h4080_0000, 0);
      step(0, 1, ONE, 0, 32'h40A0_0000, 0);
      step(0, 0, 0,   0, 32'h40A0_0000, 0);
      step(0, 1, ONE, 0, 32'h40C0_0000, 0);
      step(0, 0, 0,   0, 32'h40C0_0000, 0);
      step(0, 1, ONE, 0, 32'h40E0_0000, 0);
      step(0, 0, 0,   0, 32'h40E0_0000, 0);
      step(0, 1, ONE, 0, 32'h4100_0000, 0);
      step(0, 0, 0,   1, 32'h4100_0000, 1);
      step(0, 0, 0,   0, 32'h4100_0000, 0);

      // x + (-x) = +0
      step(1, 0, 0,            0, 32'h0000_0000, 0);
      step(0, 1, 32'h3FC00000, 0, 32'h3FC0_0000, 0);
      step(0, 1, 32'hBFC00000, 0, 32'h0000_0000, 0);
      step(0, 0, 0,            1, 32'h0000_0000, 1);
      step(0, 0, 0,            0, 32'h0000_0000, 0);

      // Restart while accumulating ignores valid
      step(1, 0, 0,            0, 32'h0000_0000, 0);
      step(0, 1, ONE,          0, 32'h3F80_0000, 0);
      step(1, 1, 32'h40000000, 0, 32'h0000_0000, 0);

      // Overflow to inf, inf + -inf -> qNaN, NaN sticks
      step(0, 1, 32'h7F7FFFFF, 0, 32'h7F7F_FFFF, 0);
      step(0, 1, 32'h7F7FFFFF, 0, 32'h7F80_0000, 0);
      step(0, 1, 32'hFF800000, 0, 32'h7FC0_0000, 0);
      step(0, 1, ONE,          1, 32'h7FC0_0000, 1);

      // Round-to-nearest-even ties and subnormal input flush
      step(1, 0, 0,            0, 32'h0000_0000, 0);
      step(0, 1, ONE,          0, 32'h3F80_0000, 0);
      step(0, 1, 32'h33800000, 0, 32'h3F80_0000, 0);
      step(0, 1, 32'h34000000, 0, 32'h3F80_0001, 0);
      step(0, 1, 32'h33800000, 0, 32'h3F80_0002, 0);
      step(0, 1, 32'h00000001, 0, 32'h3F80_0002, 0);

      // Cancellation, renormalisation, negative result
      step(1, 0, 0,            0, 32'h0000_0000, 0);
      step(0, 1, 32'h3F800001, 0, 32'h3F80_0001, 0);
      step(0, 1, 32'hBF800000, 0, 32'h3400_0000, 0);
      step(0, 1, 32'hC0000000, 0, 32'hBFFF_FFFF, 0);

      // Subnormal result flushes to signed zero
      step(1, 0, 0,            0, 32'h0000_0000, 0);
      step(0, 1, 32'h80800001, 0, 32'h8080_0001, 0);
      step(0, 1, 32'h00800000, 0, 32'h8000_0000, 0);

      // Reset mid-accumulation
      step(1, 0, 0,   0, 32'h0000_0000, 0);
      step(0, 1, ONE, 0, 32'h3F80_0000, 0);
      async_reset_check();
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 1, ONE, 0, 32'h0000_0000, 0);
      step(0, 0, 0,   1, 32'h0000_0000, 0);

      // finished with valid in the same cycle; IDLE ignores valid/finished
      step(1, 0, 0,            0, 32'h0000_0000, 0);
      step(0, 1, ONE,          0, 32'h3F80_0000, 0);
      step(0, 1, 32'h40000000, 1, 32'h4040_0000, 1);
      step(0, 1, ONE,          0, 32'h4040_0000, 0);
      step(0, 0, 0,            1, 32'h4040_0000, 0);

      @(negedge clk);
      start    = 1'b0;
      valid    = 1'b0;
      finished = 1'b0;
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain: pending=%0d, expected pending=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
